// File: rtl/grant_scheduler.sv
// grant_scheduler: four-requester round-robin grant arbiter with registered
// active-low one-hot grant, binary index and valid flag.
// Optional force-release of long-held grants is built when the macro
// GRANT_TIMEOUT_EN is defined; otherwise grants are held indefinitely.
module grant_scheduler #(
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] req,
   output logic [3:0] grant_n,
   output logic [1:0] grant_idx,
   output logic       grant_valid,
   output logic       timeout
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   logic [0:0] state_reg, state_next;
   logic [1:0] ptr_reg, ptr_next;
   logic [3:0] grant_n_reg, grant_n_next;
   logic [1:0] idx_reg, idx_next;
   logic       valid_reg, valid_next;
   logic       timeout_reg, timeout_next;

   logic [3:0] cand;       // requests eligible for this arbitration
   logic [3:0] rot;        // cand rotated so bit 0 is the pointer position
   logic       found;
   logic [1:0] offset;
   logic [1:0] win;
   logic       holder_req;
   logic       force_rel;
   logic       rearb;

   assign holder_req = req[idx_reg];

`ifdef GRANT_TIMEOUT_EN
   logic [7:0] hold_reg, hold_next;
   // Holder has used its full allowance and is still asking for more.
   assign force_rel = (state_reg == GRANT) && holder_req && (hold_reg == 8'(TIMEOUT - 1));
`else
   assign force_rel = 1'b0;
`endif

   // A force-released holder sits out this one decision only.
   assign cand  = force_rel ? (req & ~(4'b0001 << idx_reg)) : req;
   assign rearb = (state_reg == IDLE) || !holder_req || force_rel;

   // Rotate candidates so searching upward from ptr becomes a fixed priority.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_rot
         assign rot[gi] = cand[2'(ptr_reg + 2'(gi))];
      end
   endgenerate

   // Lowest set bit of the rotated vector wins; map it back to an index.
   always_comb begin
      found  = 1'b0;
      offset = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (rot[i]) begin
            found  = 1'b1;
            offset = 2'(i);
         end
      end
      win = ptr_reg + offset;
   end

   // Next-state: hold, hand off, or drop to idle.
   always_comb begin
      state_next   = state_reg;
      ptr_next     = ptr_reg;
      grant_n_next = grant_n_reg;
      idx_next     = idx_reg;
      valid_next   = valid_reg;
      timeout_next = 1'b0;
`ifdef GRANT_TIMEOUT_EN
      hold_next    = hold_reg;
`endif
      if (!rearb) begin
`ifdef GRANT_TIMEOUT_EN
         hold_next = hold_reg + 8'd1;
`endif
      end else begin
         timeout_next = force_rel;
         if (found) begin
            state_next   = GRANT;
            idx_next     = win;
            valid_next   = 1'b1;
            grant_n_next = ~(4'b0001 << win);
            ptr_next     = win + 2'd1;
`ifdef GRANT_TIMEOUT_EN
            hold_next    = 8'd0;
`endif
         end else begin
            // grant_idx keeps its last value while nothing is granted.
            state_next   = IDLE;
            valid_next   = 1'b0;
            grant_n_next = 4'b1111;
         end
      end
   end

   // State registers with synchronous reset overriding all requests.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= IDLE;
         ptr_reg     <= 2'd0;
         grant_n_reg <= 4'b1111;
         idx_reg     <= 2'd0;
         valid_reg   <= 1'b0;
         timeout_reg <= 1'b0;
`ifdef GRANT_TIMEOUT_EN
         hold_reg    <= 8'd0;
`endif
      end else begin
         state_reg   <= state_next;
         ptr_reg     <= ptr_next;
         grant_n_reg <= grant_n_next;
         idx_reg     <= idx_next;
         valid_reg   <= valid_next;
         timeout_reg <= timeout_next;
`ifdef GRANT_TIMEOUT_EN
         hold_reg    <= hold_next;
`endif
      end
   end

   assign grant_n     = grant_n_reg;
   assign grant_idx   = idx_reg;
   assign grant_valid = valid_reg;
   assign timeout     = timeout_reg;

endmodule

// File: tb/tb_grant_scheduler.sv
// Testbench for grant_scheduler: directed scenarios plus randomized requests,
// every cycle compared against a behavioural round-robin model.
module tb_grant_scheduler;

   localparam int TMO = 4;
`ifdef GRANT_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] req = 4'b0000;
   logic [3:0] grant_n;
   logic [1:0] grant_idx;
   logic       grant_valid;
   logic       timeout;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state: plain integers, -1 means no holder.
   int m_holder = -1;
   int m_idx    = 0;
   int m_ptr    = 0;
   int m_held   = 0;
   bit m_to     = 1'b0;

   grant_scheduler #(.TIMEOUT(TMO)) dut (
      .clk(clk),
      .reset(reset),
      .req(req),
      .grant_n(grant_n),
      .grant_idx(grant_idx),
      .grant_valid(grant_valid),
      .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock of the behavioural model for sampled request r.
   task automatic model(input logic [3:0] r, input logic rst);
      int excl;
      int w;
      if (rst) begin
         m_holder = -1; m_idx = 0; m_ptr = 0; m_held = 0; m_to = 1'b0;
         return;
      end
      m_to = 1'b0;
      if (m_holder >= 0 && r[m_holder] && !(TO_EN && m_held == TMO - 1)) begin
         m_held++;
         return;
      end
      excl = (m_holder >= 0 && r[m_holder]) ? m_holder : -1;
      m_to = (excl >= 0);
      w = -1;
      for (int k = 0; k < 4; k++) begin
         if (w < 0 && r[(m_ptr + k) % 4] && ((m_ptr + k) % 4) != excl)
            w = (m_ptr + k) % 4;
      end
      if (w >= 0) begin
         m_holder = w; m_idx = w; m_ptr = (w + 1) % 4; m_held = 0;
      end else begin
         m_holder = -1;
      end
   endtask

   function automatic logic [3:0] exp_gn();
      logic [3:0] one = 4'b0001;
      return (m_holder < 0) ? 4'b1111 : ~(one << m_holder);
   endfunction

   // Drive one cycle, advance the model, compare all outputs.
   task automatic step(input logic [3:0] r, input logic rst, input string tag);
      req   = r;
      reset = rst;
      @(posedge clk);
      #1;
      model(r, rst);
      chk({tag, ".grant_n"}, 8'(grant_n), 8'(exp_gn()));
      chk({tag, ".grant_idx"}, 8'(grant_idx), 8'(m_idx));
      chk({tag, ".grant_valid"}, 8'(grant_valid), 8'(m_holder >= 0));
      chk({tag, ".timeout"}, 8'(timeout), 8'(m_to));
   endtask

   initial begin
      int exp_ord[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
      logic [3:0] r;
      logic       rst;

      // Reset state and first grant latency.
      step(4'b0000, 1'b1, "reset");
      chk("reset.grant_n_const", 8'(grant_n), 8'h0F);
      step(4'b0100, 1'b0, "first");
      chk("first.grant_n_const", 8'(grant_n), 8'h0B);
      chk("first.grant_idx_const", 8'(grant_idx), 8'd2);
      chk("first.valid_const", 8'(grant_valid), 8'd1);

      // All requesting, each holder drops after two cycles: 0,1,2,3,0 back to back.
      step(4'b0000, 1'b1, "rr.reset");
      for (int i = 0; i < 10; i++) begin
         r = 4'b1111;
         if (m_holder >= 0 && m_held == 1) r[m_holder] = 1'b0;
         step(r, 1'b0, "rr");
         chk("rr.order", 8'(grant_idx), 8'(exp_ord[i]));
         chk("rr.no_dead", 8'(grant_valid), 8'd1);
      end

      // Holder 1 releases with nobody else waiting: idle, index retained.
      step(4'b0000, 1'b1, "rel.reset");
      step(4'b0010, 1'b0, "rel.grant");
      step(4'b0010, 1'b0, "rel.hold");
      step(4'b0000, 1'b0, "rel.drop");
      chk("rel.grant_n_const", 8'(grant_n), 8'h0F);
      chk("rel.valid_const", 8'(grant_valid), 8'd0);
      chk("rel.idx_const", 8'(grant_idx), 8'd1);
      step(4'b0000, 1'b0, "rel.idle");

`ifdef GRANT_TIMEOUT_EN
      // Requester 0 overstays with 1 waiting: four cycles, then forced handoff.
      step(4'b0000, 1'b1, "tmo.reset");
      for (int i = 0; i < 4; i++) begin
         step(4'b0011, 1'b0, "tmo.hold0");
         chk("tmo.hold0_const", 8'(grant_n), 8'h0E);
      end
      step(4'b0011, 1'b0, "tmo.handoff");
      chk("tmo.pulse_const", 8'(timeout), 8'd1);
      chk("tmo.grant1_const", 8'(grant_n), 8'h0D);
      for (int i = 0; i < 8; i++) step(4'b0011, 1'b0, "tmo.cont");
`else
      // Without force-release a lone requester keeps its grant indefinitely.
      step(4'b0000, 1'b1, "long.reset");
      for (int i = 0; i < 300; i++) begin
         step(4'b0001, 1'b0, "long");
         chk("long.grant_n_const", 8'(grant_n), 8'h0E);
         chk("long.timeout_const", 8'(timeout), 8'd0);
      end
`endif

      // Reset mid-grant drops the grant; arbitration restarts from ptr 0.
      step(4'b0000, 1'b1, "mid.reset");
      step(4'b1000, 1'b0, "mid.grant3");
      chk("mid.grant3_const", 8'(grant_n), 8'h07);
      step(4'b1000, 1'b1, "mid.assert");
      chk("mid.drop_const", 8'(grant_n), 8'h0F);
      step(4'b1001, 1'b0, "mid.after");
      chk("mid.grant0_const", 8'(grant_idx), 8'd0);
      chk("mid.grant0_n_const", 8'(grant_n), 8'h0E);

      // Randomized traffic; holders tend to keep asking so grants persist.
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 59) == 0);
         r   = 4'($urandom);
         if (m_holder >= 0 && $urandom_range(0, 3) != 0) r[m_holder] = 1'b1;
         step(r, rst, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/grant_scheduler.md
GRANT_SCHEDULER -- requirements
Module: grant_scheduler

Interface
REQ-001 SHALL have parameter: TIMEOUT, default 16, maximum cycles one requester may hold the grant (legal range 2..255).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: req  input  4  active-high request, one bit per requester 0..3.
REQ-005 SHALL have port: grant_n  output  4  registered active-low one-hot grant: 1110 = requester 0, 1101 = 1, 1011 = 2, 0111 = 3, 1111 = none.
REQ-006 SHALL have port: grant_idx  output  2  registered binary index of the current grant holder.
REQ-007 SHALL have port: grant_valid  output  1  registered; high while any grant_n bit is low.
REQ-008 SHALL have port: timeout  output  1  registered one-cycle pulse when a grant is force-released.

Function
REQ-009 SHALL implement two states: IDLE (no grant) and GRANT (one holder).
REQ-010 SHALL, in IDLE, treat any set req bit as an arbitration request.
REQ-011 SHALL select the first set req bit, searching upward modulo 4 from the rotating pointer ptr.
REQ-012 SHALL drive the winning grant on grant_n, grant_idx and grant_valid on the edge after req is sampled (1-cycle latency).
REQ-013 SHALL, on each grant issue, set ptr to (winner+1) mod 4; 3 wraps to 0.
REQ-014 SHALL, in GRANT, hold the grant unchanged while req[grant_idx] stays high.
REQ-015 SHALL, in the cycle req[grant_idx] is sampled low, re-arbitrate using the updated ptr.
REQ-016 SHALL, on that re-arbitration edge, hand off directly to the winner with no dead cycle if any other req bit is set.
REQ-017 SHALL, on that re-arbitration edge, go to IDLE with grant_n=1111 and grant_valid=0 if no req bit is set.
REQ-018 SHALL let the releasing requester win only when it re-requests and no other requester is pending.
REQ-019 SHALL let ptr order alone decide simultaneous requests; grant_n SHALL never have more than one bit low.
REQ-020 SHALL hold grant_idx at its last value whenever grant_valid=0.
REQ-021 SHALL keep grant_n consistent with grant_idx and grant_valid every cycle.
REQ-022 SHALL run a hold counter, 8 bits wide, cleared to 0 on every grant issue and incremented each cycle in GRANT.

Reset
REQ-023 SHALL, on reset sampled high, set state=IDLE, grant_n=1111, grant_idx=0, grant_valid=0, timeout=0, ptr=0 and hold counter=0 at that edge.
REQ-024 SHALL, on reset asserted mid-grant, drop the grant at that edge; reset SHALL override all requests.
REQ-025 SHALL arbitrate from ptr=0 on the first cycle after reset deasserts.

Configuration
REQ-026 SHALL implement force-release only when macro GRANT_TIMEOUT_EN is defined.
REQ-027 SHALL, with GRANT_TIMEOUT_EN defined, force release when the hold counter reaches TIMEOUT-1 while the holder's req is still high.
REQ-028 SHALL, on force release, pulse timeout for one cycle on the next edge.
REQ-029 SHALL, on force release, re-arbitrate with the current holder excluded for that decision only: hand off if others pend, else go to IDLE.
REQ-030 SHALL let a force-released requester still requesting win later, after at least one IDLE cycle or another holder.
REQ-031 SHALL, without GRANT_TIMEOUT_EN, hold grants indefinitely, tie timeout to 0, and omit the hold counter.

Verification
REQ-032 SHALL cover: reset, then req=0100 at cycle 0 -> cycle 1 grant_n=1011, grant_idx=2, grant_valid=1.
REQ-033 SHALL cover: req=1111 held, each holder drops req after 2 cycles and reasserts -> grant order 0,1,2,3,0 with no dead cycles.
REQ-034 SHALL cover: holder 1 drops req while req=0000 -> next edge grant_n=1111, grant_valid=0, grant_idx stays 1.
REQ-035 SHALL cover: GRANT_TIMEOUT_EN, TIMEOUT=4, req=0011 held -> 0 holds 4 cycles, timeout pulses, 1 granted next edge.
REQ-036 SHALL cover: GRANT_TIMEOUT_EN undefined, req=0001 held 300 cycles -> grant_n=1110 throughout, timeout=0.
REQ-037 SHALL cover: reset asserted while grant_n=0111 -> next edge grant_n=1111; after release req=1001 -> 0 granted.
